// File: rtl/irq_pending.sv
// irq_pending: 8-line interrupt pending register feeding an 8-to-3 priority
// encoder. Every request line passes through a 2-flop synchronizer and a
// history flop. Events are latched into pend either as rising edges (EDGE=1)
// or as levels (EDGE=0). Lines are cleared by a one-hot ack and gated by a
// mask register before they reach the encoder.
//
// Parameters:
//   EDGE        1 = rising-edge capture, 0 = level capture
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   irq[7:0]    asynchronous request lines (bit 7 highest priority downstream)
//   mask_wr     one-cycle strobe that loads mask_data into the mask register
//   mask_data   new mask value, 1 = line masked
//   ack_valid   one-cycle strobe that acknowledges line ack_code
//   ack_code    index of the acknowledged line
//   pending     pend & ~mask, wired straight to the priority encoder
//   ovf         per-line sticky overflow flags      (IRQ_OVERFLOW_EN only)
//   ovf_clr     clears every ovf bit                (IRQ_OVERFLOW_EN only)
//   any_pending OR-reduction of pending
// Build option: define IRQ_OVERFLOW_EN to add the overflow flags.
module irq_pending #(
  parameter int EDGE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  input  logic       ack_valid,
  input  logic [2:0] ack_code,
  output logic [7:0] pending,
`ifdef IRQ_OVERFLOW_EN
  output logic [7:0] ovf,
  input  logic       ovf_clr,
`endif
  output logic       any_pending
);

  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] s3;
  logic [7:0] pend;
  logic [7:0] mask;
  logic [7:0] set;
  logic [7:0] clr;

  // Synchronizer plus history flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 is reset to 0, so a line held high through reset is seen as a rise.
  assign set = (EDGE != 0) ? (s2 & ~s3) : s2;

  always_comb begin
    clr = '0;
    if (ack_valid) clr[ack_code] = 1'b1;
  end

  // Set is ORed in after the clear so a coincident event is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= (pend & ~clr) | set;
      if (mask_wr) mask <= mask_data;
    end
  end

  assign pending     = pend & ~mask;
  assign any_pending = |pending;

`ifdef IRQ_OVERFLOW_EN
  logic [7:0] ovf_set;

  // An overflow is a new edge on a line that is still pending and not being
  // acknowledged on the same edge. Level mode has no notion of a repeat edge.
  assign ovf_set = (EDGE != 0) ? (set & pend & ~clr) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~{8{ovf_clr}}) | ovf_set;
    end
  end
`endif

endmodule

// File: tb/tb_irq_pending.sv
// Directed bench for irq_pending: a vector table for the main edge-mode
// sequences, plus hand-written sequences for overflow and level-mode ack.
module tb_irq_pending;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       ack_valid;
  logic [2:0] ack_code;
  logic [7:0] pending;
  logic       any_pending;

  logic [7:0] irq_l;
  logic       ack_valid_l;
  logic [2:0] ack_code_l;
  logic [7:0] pending_l;
  logic       any_pending_l;

`ifdef IRQ_OVERFLOW_EN
  logic [7:0] ovf;
  logic       ovf_clr;
  logic [7:0] ovf_l;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_pending #(.EDGE(1)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .mask_wr(mask_wr),
    .mask_data(mask_data), .ack_valid(ack_valid), .ack_code(ack_code),
    .pending(pending),
`ifdef IRQ_OVERFLOW_EN
    .ovf(ovf), .ovf_clr(ovf_clr),
`endif
    .any_pending(any_pending)
  );

  irq_pending #(.EDGE(0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .irq(irq_l), .mask_wr(1'b0),
    .mask_data(8'h00), .ack_valid(ack_valid_l), .ack_code(ack_code_l),
    .pending(pending_l),
`ifdef IRQ_OVERFLOW_EN
    .ovf(ovf_l), .ovf_clr(1'b0),
`endif
    .any_pending(any_pending_l)
  );

  typedef struct {
    logic       rst_n;
    logic [7:0] irq;
    logic       mwr;
    logic [7:0] mdata;
    logic       av;
    logic [2:0] ac;
    logic [7:0] ep;
    logic       ea;
    logic [2:0] ee;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [2:0] enc(input logic [7:0] p);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (p[i]) r = 3'(i);
    return r;
  endfunction

  function automatic vec_t mk(input logic r, input logic [7:0] i, input logic mw,
                              input logic [7:0] md, input logic av, input logic [2:0] ac,
                              input logic [7:0] ep, input logic [2:0] ee);
    vec_t v;
    v.rst_n = r; v.irq = i; v.mwr = mw; v.mdata = md;
    v.av = av; v.ac = ac; v.ep = ep; v.ea = |ep; v.ee = ee;
    return v;
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; mask_wr = 1'b0; mask_data = '0;
    ack_valid = 1'b0; ack_code = '0;
    irq_l = '0; ack_valid_l = 1'b0; ack_code_l = '0;
`ifdef IRQ_OVERFLOW_EN
    ovf_clr = 1'b0;
`endif

    //                 rst  irq    mwr md    av ac   exp_pend enc
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0)); // reset
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0));
    vecs.push_back(mk(1, 8'h04, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0)); // first sample of bit2
    vecs.push_back(mk(1, 8'h04, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0));
    vecs.push_back(mk(1, 8'h04, 0, 8'h00, 0, 3'd0, 8'h04, 3'd2)); // +2 edges
    vecs.push_back(mk(1, 8'h84, 0, 8'h00, 0, 3'd0, 8'h04, 3'd2));
    vecs.push_back(mk(1, 8'h84, 0, 8'h00, 0, 3'd0, 8'h04, 3'd2));
    vecs.push_back(mk(1, 8'h84, 0, 8'h00, 0, 3'd0, 8'h84, 3'd7));
    vecs.push_back(mk(1, 8'h84, 0, 8'h00, 1, 3'd7, 8'h04, 3'd2)); // ack 7
    vecs.push_back(mk(1, 8'h84, 0, 8'h00, 0, 3'd0, 8'h04, 3'd2));
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 1, 3'd2, 8'h00, 3'd0)); // ack 2
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0));
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0));
    vecs.push_back(mk(1, 8'h01, 1, 8'hFF, 0, 3'd0, 8'h00, 3'd0)); // mask all, bit0 pulse
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0));
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0)); // pend=01 but masked
    vecs.push_back(mk(1, 8'h00, 1, 8'h00, 0, 3'd0, 8'h01, 3'd0)); // unmask
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 1, 3'd0, 8'h00, 3'd0)); // ack 0
    vecs.push_back(mk(1, 8'h20, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0)); // bit5 pulse 1
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0));
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 3'd0, 8'h20, 3'd5));
    vecs.push_back(mk(1, 8'h20, 0, 8'h00, 0, 3'd0, 8'h20, 3'd5)); // bit5 pulse 2
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 3'd0, 8'h20, 3'd5));
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 1, 3'd5, 8'h20, 3'd5)); // ack 5 with set 5
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 1, 3'd5, 8'h00, 3'd0)); // ack 5 alone
    vecs.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0));
    vecs.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0));
    vecs.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 3'd0, 8'hFF, 3'd7));
    vecs.push_back(mk(0, 8'hFF, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0)); // reset mid-run
    vecs.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0));
    vecs.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0));
    vecs.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 3'd0, 8'hFF, 3'd7)); // re-detected
    vecs.push_back(mk(1, 8'hFF, 1, 8'h0F, 1, 3'd7, 8'h70, 3'd6)); // mask+ack same edge
    vecs.push_back(mk(1, 8'h00, 1, 8'h00, 0, 3'd0, 8'h7F, 3'd6));
    vecs.push_back(mk(1, 8'h00, 1, 8'hFF, 1, 3'd0, 8'h00, 3'd0)); // ack of bit0 (masked)
    vecs.push_back(mk(1, 8'h00, 1, 8'h00, 0, 3'd0, 8'h7E, 3'd6)); // only bit0 gone

    for (int n = 0; n < vecs.size(); n++) begin
      rst_n     = vecs[n].rst_n;
      irq       = vecs[n].irq;
      mask_wr   = vecs[n].mwr;
      mask_data = vecs[n].mdata;
      ack_valid = vecs[n].av;
      ack_code  = vecs[n].ac;
      tick();
      chk8($sformatf("v%0d pending", n), pending, vecs[n].ep);
      chk8($sformatf("v%0d any_pending", n), {7'd0, any_pending}, {7'd0, vecs[n].ea});
      chk8($sformatf("v%0d encoder", n), {5'd0, enc(pending)}, {5'd0, vecs[n].ee});
    end

    // Clean restart for the hand sequences.
    rst_n = 1'b0; irq = '0; mask_wr = 1'b0; ack_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk8("restart pending", pending, 8'h00);

`ifdef IRQ_OVERFLOW_EN
    chk8("ovf after reset", ovf, 8'h00);
    irq = 8'h08; tick(); irq = 8'h00;
    repeat (3) tick();
    chk8("first bit3 pulse pending", pending, 8'h08);
    chk8("first bit3 pulse ovf", ovf, 8'h00);
    irq = 8'h08; tick(); irq = 8'h00;
    repeat (3) tick();
    chk8("second bit3 pulse pending", pending, 8'h08);
    chk8("second bit3 pulse ovf", ovf, 8'h08);
    tick();
    chk8("ovf sticky", ovf, 8'h08);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk8("ovf cleared", ovf, 8'h00);
    chk8("pending kept after ovf_clr", pending, 8'h08);
    ack_valid = 1'b1; ack_code = 3'd3; tick(); ack_valid = 1'b0;
    chk8("bit3 acked", pending, 8'h00);
`endif

    // Level mode: ack while the line is still high is overridden.
    irq_l = 8'h02;
    repeat (3) tick();
    chk8("level pend", pending_l, 8'h02);
    ack_valid_l = 1'b1; ack_code_l = 3'd1; tick(); ack_valid_l = 1'b0;
    chk8("level ack while high", pending_l, 8'h02);
    irq_l = 8'h00;
    repeat (3) tick();
    chk8("level held after drop", pending_l, 8'h02);
    ack_valid_l = 1'b1; ack_code_l = 3'd1; tick(); ack_valid_l = 1'b0;
    chk8("level ack after drop", pending_l, 8'h00);
    chk8("level any_pending", {7'd0, any_pending_l}, 8'h00);
`ifdef IRQ_OVERFLOW_EN
    chk8("level mode ovf", ovf_l, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_pending.md
IRQ_PENDING -- requirements
Module: irq_pending

Interface
REQ-001 The block SHALL have parameter EDGE, default 1, where 1 = rising-edge capture and 0 = level capture.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; it SHALL be synchronous and active-low.
REQ-004 The block SHALL have port irq, input, 8, asynchronous request lines; bit 7 is highest priority downstream.
REQ-005 The block SHALL have port mask_wr, input, 1, a one-cycle strobe that loads the mask register.
REQ-006 The block SHALL have port mask_data, input, 8, the new mask value, where 1 = line masked.
REQ-007 The block SHALL have port ack_valid, input, 1, a one-cycle strobe that acknowledges one line.
REQ-008 The block SHALL have port ack_code, input, 3, the index of the acknowledged line, qualified by ack_valid.
REQ-009 The block SHALL have port pending, output, 8, equal to pend & ~mask; it drives the 8-to-3 priority encoder input directly.
REQ-010 The block SHALL have port any_pending, output, 1, equal to the OR-reduction of pending.
REQ-011 The block SHALL have port ovf, output, 8, per-line sticky overflow flags (present only with IRQ_OVERFLOW_EN).
REQ-012 The block SHALL have port ovf_clr, input, 1, a strobe that clears all ovf bits (present only with IRQ_OVERFLOW_EN).

Function
REQ-013 Each irq bit SHALL pass through a 2-flop synchronizer (s1, s2), followed by a history flop s3.
REQ-014 The set term SHALL be: EDGE=1 -> set = s2 & ~s3; EDGE=0 -> set = s2.
REQ-015 The clear term SHALL be: clr = ack_valid ? one-hot(ack_code) : 8'h00.
REQ-016 The pend register SHALL update as pend_next = (pend & ~clr) | set, so set wins when set and clear hit the same bit in the same cycle.
REQ-017 Latency: if irq[i] is stable high before clk edge E0, pend[i] SHALL become 1 after edge E2, and pending[i] SHALL follow in the same cycle if unmasked.
REQ-018 pending and any_pending SHALL be combinational from the pend and mask registers, with no added cycle.
REQ-019 Masking SHALL gate only the pending output; masked lines SHALL still latch into pend and SHALL appear when unmasked.
REQ-020 mask_wr SHALL load mask_data on the next edge, and the new mask SHALL take effect on pending in the following cycle.
REQ-021 An ack of a bit already 0, or of a masked bit, SHALL clear pend for that bit (no-op if already 0) and SHALL affect no other bit.
REQ-022 A new rise on a line whose pend bit is already 1 (EDGE=1) SHALL leave pend at 1; the event is merged.
REQ-023 In EDGE=0 mode, an ack while irq is still high SHALL be overridden by set, so the bit stays 1.
REQ-024 mask_wr, ack_valid and irq events in the same cycle SHALL all take effect independently on the same edge.

Reset
REQ-025 While rst_n=0 at a clk edge, s1, s2, s3, pend and ovf SHALL load 0, and mask SHALL load 8'h00.
REQ-026 During reset, pending SHALL be 8'h00 and any_pending SHALL be 0.
REQ-027 A line held high through reset SHALL be detected as a rising edge two cycles after rst_n rises.
REQ-028 Reset asserted mid-operation SHALL discard all pending and overflow state within one edge.

Configuration
REQ-029 With macro IRQ_OVERFLOW_EN defined, ports ovf and ovf_clr SHALL exist.
REQ-030 With IRQ_OVERFLOW_EN defined, ovf[i] SHALL set when set[i]=1, pend[i]=1 and clr[i]=0 in the same cycle (EDGE=1 only).
REQ-031 With IRQ_OVERFLOW_EN defined, ovf[i] SHALL hold until ovf_clr or reset; if ovf_clr and a new overflow coincide, set SHALL win.
REQ-032 Without IRQ_OVERFLOW_EN, ovf and ovf_clr SHALL be absent, no overflow logic SHALL be built, and all other behaviour SHALL be identical.

Verification
REQ-033 Bench SHALL cover: after reset, irq=8'h04 rising -> pending=8'h04 and any_pending=1 exactly 2 cycles after first sampling edge, with the downstream encoder reading 3'b010.
REQ-034 Bench SHALL cover: pend=8'h84, ack_valid=1, ack_code=7 -> next cycle pending=8'h04, and the encoder switches from 3'b111 to 3'b010.
REQ-035 Bench SHALL cover: mask=8'hFF, irq bit0 pulse -> pending=8'h00; then mask_wr with mask_data=8'h00 -> pending=8'h01.
REQ-036 Bench SHALL cover: a rise on bit 5 on the same edge as ack_code=5 -> pend[5] stays 1.
REQ-037 Bench SHALL cover (IRQ_OVERFLOW_EN): two bit-3 pulses with no ack between -> ovf=8'h08; ovf_clr -> ovf=8'h00.
REQ-038 Bench SHALL cover: rst_n=0 for one edge with pend=8'hFF -> pending=8'h00 on the next cycle, and irq held high is re-detected 2 cycles after release.
